// File: rtl/baby_kyber_encrypt.sv
// baby_kyber_encrypt: Baby Kyber encryption over Z_Q[x]/(x^4+1).
// Computes u = A^T*r + e1 and v = t^T*r + e2 + msg*MSG_SCALE with one coefficient MAC.
//
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   in_valid/in_ready   - input bundle handshake (in_ready = engine idle)
//   pk_a, pk_t          - public key: A00,A01,A10,A11 and t0,t1 (signed coeffs)
//   r, e1, e2, msg      - ephemeral secret, errors, 4-bit message
//   out_valid/out_ready - ciphertext handshake
//   ct_u, ct_v          - ciphertext u0,u1 and v, coefficients in [0, Q-1]
module baby_kyber_encrypt #(
    parameter int Q         = 17,
    parameter int MSG_SCALE = 9,
    parameter int DATA_W    = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [3:0][3:0][DATA_W-1:0] pk_a,
    input  logic signed [1:0][3:0][DATA_W-1:0] pk_t,
    input  logic signed [1:0][3:0][DATA_W-1:0] r,
    input  logic signed [1:0][3:0][DATA_W-1:0] e1,
    input  logic signed [3:0][DATA_W-1:0]      e2,
    input  logic [3:0]                         msg,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [1:0][3:0][DATA_W-1:0] ct_u,
    output logic signed [3:0][DATA_W-1:0]      ct_v
);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    localparam int CW    = $clog2(Q);
    localparam int PW    = 2 * CW;
    localparam int ACC_W = 13;
    localparam logic [6:0] LAST_CNT = 7'd95;

    // Signed modulo that always lands in [0, Q-1].
    function automatic logic [CW-1:0] mod_q(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] m;
        m = x % DATA_W'(Q);
        if (m < 0) m = m + DATA_W'(Q);
        return CW'(m);
    endfunction

    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic [6:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    // Raw captured bundle.
    logic [3:0][3:0][DATA_W-1:0] a_raw_q, a_raw_d;
    logic [1:0][3:0][DATA_W-1:0] t_raw_q, t_raw_d;
    logic [1:0][3:0][DATA_W-1:0] r_raw_q, r_raw_d;
    logic [1:0][3:0][DATA_W-1:0] e1_raw_q, e1_raw_d;
    logic [3:0][DATA_W-1:0]      e2_raw_q, e2_raw_d;
    logic [3:0]                  msg_q, msg_d;

    // Normalised operands.
    logic [3:0][3:0][CW-1:0] a_n_q, a_n_d;
    logic [1:0][3:0][CW-1:0] t_n_q, t_n_d;
    logic [1:0][3:0][CW-1:0] r_n_q, r_n_d;
    logic [1:0][3:0][CW-1:0] e1_n_q, e1_n_d;
    logic [3:0][CW-1:0]      e2_n_q, e2_n_d;

    logic [1:0][3:0][DATA_W-1:0] ct_u_q, ct_u_d;
    logic [3:0][DATA_W-1:0]      ct_v_q, ct_v_d;

    // Counter fields: o (output poly), k (output coeff), p (term), i (a coeff).
    logic [1:0] o, k, i, j;
    logic       p, neg, first, last;
    logic [CW-1:0] a_c, b_c, err, mbit, res;
    logic [PW-1:0] prod;
    logic signed [ACC_W-1:0] term, acc_sum;
    logic signed [ACC_W:0]   fin;

    assign o     = cnt_q[6:5];
    assign k     = cnt_q[4:3];
    assign p     = cnt_q[2];
    assign i     = cnt_q[1:0];
    assign j     = k - i;
    assign neg   = (i > k);
    assign first = !p && (i == 2'd0);
    assign last  = p && (i == 2'd3);

    always_comb begin
        case (o)
            2'd0:    a_c = a_n_q[{p, 1'b0}][i];
            2'd1:    a_c = a_n_q[{p, 1'b1}][i];
            default: a_c = t_n_q[p][i];
        endcase
        b_c  = r_n_q[p][j];
        prod = PW'(a_c) * PW'(b_c);
        // x^i * x^j wraps past x^3 when i > k, and x^4 = -1.
        term = ACC_W'(prod);
        if (neg) term = -term;
        acc_sum = first ? term : acc_q + term;
        err  = (o == 2'd2) ? e2_n_q[k] : e1_n_q[o[0]][k];
        mbit = (o == 2'd2 && msg_q[k]) ? CW'(MSG_SCALE) : '0;
        fin  = (ACC_W + 1)'(acc_sum)
             + $signed((ACC_W + 1)'(err))
             + $signed((ACC_W + 1)'(mbit));
        res  = mod_q(DATA_W'(fin));
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_raw_d     = a_raw_q;
        t_raw_d     = t_raw_q;
        r_raw_d     = r_raw_q;
        e1_raw_d    = e1_raw_q;
        e2_raw_d    = e2_raw_q;
        msg_d       = msg_q;
        a_n_d       = a_n_q;
        t_n_d       = t_n_q;
        r_n_d       = r_n_q;
        e1_n_d      = e1_n_q;
        e2_n_d      = e2_n_q;
        ct_u_d      = ct_u_q;
        ct_v_d      = ct_v_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_raw_d    = pk_a;
                    t_raw_d    = pk_t;
                    r_raw_d    = r;
                    e1_raw_d   = e1;
                    e2_raw_d   = e2;
                    msg_d      = msg;
                    in_ready_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                for (int x = 0; x < 4; x++) begin
                    for (int y = 0; y < 4; y++) begin
                        a_n_d[x][y] = mod_q(a_raw_q[x][y]);
                    end
                end
                for (int x = 0; x < 2; x++) begin
                    for (int y = 0; y < 4; y++) begin
                        t_n_d[x][y]  = mod_q(t_raw_q[x][y]);
                        r_n_d[x][y]  = mod_q(r_raw_q[x][y]);
                        e1_n_d[x][y] = mod_q(e1_raw_q[x][y]);
                    end
                end
                for (int y = 0; y < 4; y++) begin
                    e2_n_d[y] = mod_q(e2_raw_q[y]);
                end
                cnt_d   = '0;
                acc_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_sum;
                if (last) begin
                    if (o == 2'd2) ct_v_d[k] = DATA_W'(res);
                    else ct_u_d[o[0]][k] = DATA_W'(res);
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_raw_q     <= '0;
            t_raw_q     <= '0;
            r_raw_q     <= '0;
            e1_raw_q    <= '0;
            e2_raw_q    <= '0;
            msg_q       <= '0;
            a_n_q       <= '0;
            t_n_q       <= '0;
            r_n_q       <= '0;
            e1_n_q      <= '0;
            e2_n_q      <= '0;
            ct_u_q      <= '0;
            ct_v_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_raw_q     <= a_raw_d;
            t_raw_q     <= t_raw_d;
            r_raw_q     <= r_raw_d;
            e1_raw_q    <= e1_raw_d;
            e2_raw_q    <= e2_raw_d;
            msg_q       <= msg_d;
            a_n_q       <= a_n_d;
            t_n_q       <= t_n_d;
            r_n_q       <= r_n_d;
            e1_n_q      <= e1_n_d;
            e2_n_q      <= e2_n_d;
            ct_u_q      <= ct_u_d;
            ct_v_q      <= ct_v_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ct_u      = ct_u_q;
    assign ct_v      = ct_v_q;

endmodule

// File: tb/tb_baby_kyber_encrypt.sv
// tb_baby_kyber_encrypt: scoreboard bench for baby_kyber_encrypt.
// Expected ciphertexts come from a plain polynomial-arithmetic model or hand constants.
module tb_baby_kyber_encrypt;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid;
    logic signed [3:0][3:0][DW-1:0] pk_a;
    logic signed [1:0][3:0][DW-1:0] pk_t, r, e1, ct_u;
    logic signed [3:0][DW-1:0]      e2, ct_v;
    logic [3:0] msg;

    baby_kyber_encrypt #(.Q(17), .MSG_SCALE(9), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pk_a(pk_a), .pk_t(pk_t), .r(r), .e1(e1), .e2(e2), .msg(msg),
        .out_valid(out_valid), .out_ready(out_ready),
        .ct_u(ct_u), .ct_v(ct_v)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0][3:0][4:0] u;
        logic [3:0][4:0]      v;
        int                   acc;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;
    bit pv = 1'b0;

    int sa[4][4];
    int st[2][4];
    int sr[2][4];
    int se1[2][4];
    int se2[4];
    logic [3:0] smsg;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int nq(input int x);
        int m;
        m = x % 17;
        if (m < 0) m += 17;
        return m;
    endfunction

    // Reference: direct negacyclic polynomial products, then add errors/message.
    function automatic exp_t model();
        exp_t e;
        int acc[3][4];
        int d, s;
        e = '0;
        for (int o = 0; o < 3; o++)
            for (int k = 0; k < 4; k++) acc[o][k] = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    d = a + b;
                    s = (d >= 4) ? -1 : 1;
                    d = d % 4;
                    acc[0][d] += s * nq(sa[2*p][a]) * nq(sr[p][b]);
                    acc[1][d] += s * nq(sa[2*p+1][a]) * nq(sr[p][b]);
                    acc[2][d] += s * nq(st[p][a]) * nq(sr[p][b]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            e.u[0][k] = 5'(nq(acc[0][k] + nq(se1[0][k])));
            e.u[1][k] = 5'(nq(acc[1][k] + nq(se1[1][k])));
            e.v[k] = 5'(nq(acc[2][k] + nq(se2[k]) + (smsg[k] ? 9 : 0)));
        end
        return e;
    endfunction

    task automatic clear_stim();
        for (int a = 0; a < 4; a++)
            for (int c = 0; c < 4; c++) sa[a][c] = 0;
        for (int a = 0; a < 2; a++) begin
            for (int c = 0; c < 4; c++) begin
                st[a][c] = 0;
                sr[a][c] = 0;
                se1[a][c] = 0;
            end
        end
        for (int c = 0; c < 4; c++) se2[c] = 0;
        smsg = 4'd0;
    endtask

    function automatic int rc();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 16));
            1: v = -int'($urandom_range(0, 40));
            2: v = int'($urandom);
            default: v = int'($urandom_range(0, 200)) - 100;
        endcase
        return v;
    endfunction

    task automatic rnd_stim();
        for (int a = 0; a < 4; a++)
            for (int c = 0; c < 4; c++) sa[a][c] = rc();
        for (int a = 0; a < 2; a++) begin
            for (int c = 0; c < 4; c++) begin
                st[a][c] = rc();
                sr[a][c] = rc();
                se1[a][c] = rc();
            end
        end
        for (int c = 0; c < 4; c++) se2[c] = rc();
        smsg = 4'($urandom);
    endtask

    task automatic apply();
        for (int a = 0; a < 4; a++)
            for (int c = 0; c < 4; c++) pk_a[a][c] = sa[a][c];
        for (int a = 0; a < 2; a++) begin
            for (int c = 0; c < 4; c++) begin
                pk_t[a][c] = st[a][c];
                r[a][c] = sr[a][c];
                e1[a][c] = se1[a][c];
            end
        end
        for (int c = 0; c < 4; c++) e2[c] = se2[c];
        msg = smsg;
    endtask

    task automatic send(input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", in_ready, 1);
        end else begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Monitor: latency on each rising out_valid, contents on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (out_valid && !pv && sb.size() > 0) begin
                chk("latency", cyc - sb[0].acc, 97);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: out_valid with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    for (int o = 0; o < 2; o++)
                        for (int k = 0; k < 4; k++)
                            chk($sformatf("u%0d[%0d]", o, k), ct_u[o][k], e.u[o][k]);
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("v[%0d]", k), ct_v[k], e.v[k]);
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        exp_t e, e3;
        int n;
        bit seen;
        logic [1:0][3:0][DW-1:0] su;
        logic [3:0][DW-1:0] sv;

        clear_stim();
        apply();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ct_u_zero", ct_u == '0, 1);
        chk("rst_ct_v_zero", ct_v == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Message only.
        clear_stim();
        smsg = 4'b0101;
        apply();
        e = '0;
        e.v[0] = 5'd9;
        e.v[2] = 5'd9;
        send(e);
        drain();

        // Negacyclic wrap.
        clear_stim();
        sa[0][1] = 1;
        sr[0][3] = 1;
        st[0][0] = 1;
        apply();
        e3 = '0;
        e3.u[0][0] = 5'd16;
        e3.v[3] = 5'd1;
        send(e3);
        drain();

        // Normalisation of negative and large errors.
        clear_stim();
        se1[0][0] = -1;
        se2[0] = -18;
        se2[1] = 35;
        apply();
        e = '0;
        e.u[0][0] = 5'd16;
        e.v[0] = 5'd16;
        e.v[1] = 5'd1;
        send(e);
        drain();

        // Backpressure with a pending second bundle.
        @(posedge clk);
        #1 out_ready = 1'b0;
        rnd_stim();
        apply();
        send(model());
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid_wait", out_valid, 1);
        su = ct_u;
        sv = ct_v;
        rnd_stim();
        apply();
        e = model();
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_ct_stable", (ct_u == su) && (ct_v == sv), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        e.acc = cyc + 2;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_accepted", in_ready, 0);
        drain();

        // Reset during MAC cycle 40.
        clear_stim();
        sa[0][1] = 1;
        sr[0][3] = 1;
        st[0][0] = 1;
        apply();
        send(e3);
        repeat (41) @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_ct_u_zero", ct_u == '0, 1);
        chk("mid_rst_ct_v_zero", ct_v == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_output", seen, 0);
        send(e3);
        drain();

        // Random bundles with random output backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 20; t++) begin
            rnd_stim();
            apply();
            send(model());
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/baby_kyber_encrypt.md
Name: baby_kyber_encrypt

Overview:
Baby Kyber encryption engine and the consumer of the key-generation output. It takes a public key (matrix A of 4 polynomials and vector t of 2 polynomials) plus r, e1, e2 and a 4-bit message, and produces the ciphertext u = A^T·r + e1 and v = t^T·r + e2 + m·MSG_SCALE. All arithmetic is in Z_Q[x]/(x^4+1). A single time-multiplexed coefficient MAC does the work, and valid/ready handshakes sit on both input and output.

Parameters:
Q, 17, coefficient modulus; all outputs lie in [0, Q-1]
MSG_SCALE, 9, message bit encoding, round(Q/2)
DATA_W, 32, signed coefficient width of all data ports

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input bundle valid
in_ready  output  1  engine idle; accepts the bundle when in_valid && in_ready
pk_a  input  [3:0][3:0] x DATA_W signed  A polys: [0]=A00, [1]=A01, [2]=A10, [3]=A11, coeff index = power of x
pk_t  input  [1:0][3:0] x DATA_W signed  public t0, t1
r  input  [1:0][3:0] x DATA_W signed  ephemeral secret r0, r1
e1  input  [1:0][3:0] x DATA_W signed  error added to u
e2  input  [3:0] x DATA_W signed  error added to v
msg  input  4  message bit k encodes into coeff k of v
out_valid  output  1  ciphertext valid
out_ready  input  1  sink accepts ciphertext when out_valid && out_ready
ct_u  output  [1:0][3:0] x DATA_W signed  u0, u1
ct_v  output  [3:0] x DATA_W signed  v

Behaviour:
- Reset (async, any state): state IDLE; in_ready=1, out_valid=0; ct_u and ct_v all 0; counters and accumulator 0. A reset during LOAD or MAC aborts the transaction with no partial output.
- FSM:
  - IDLE: in_ready=1. On the accept edge E0, register all inputs and go to LOAD.
  - LOAD: 1 cycle. Normalise every registered coefficient to [0, Q-1] with ((x % Q) + Q) % Q, so negatives map correctly (for example -1 maps to 16 and -18 maps to 16). Go to MAC.
  - MAC: exactly 96 cycles, one product per cycle. Go to DONE.
  - DONE: out_valid=1. On the out_valid && out_ready edge, return to IDLE.
- Latency: out_valid rises on the 97th rising edge after E0. in_ready is 0 from E0 until DONE exits. in_valid outside IDLE is ignored.
- Counter: 7-bit counter 0..95, decomposed from MSB to LSB as o (0..2: u0, u1, v), k (output coeff 0..3), p (term 0..1), i (0..3).
  - Operands:
    - o=0: a=A[2p], b=r[p].
    - o=1: a=A[2p+1], b=r[p].
    - o=2: a=t[p], b=r[p].
  - Term: coeff i of a times coeff j of b, where j=(k-i) mod 4. Negate the product when i>k (negacyclic wrap, x^4 = -1).
- Accumulator: signed, at least 13 bits; 8 terms of magnitude ≤256 give range ±2048.
  - The accumulator clears at the first term of each (o,k).
  - On the last term (p=1, i=3), write (acc + term + err + mbit) reduced to [0, Q-1] into the output register for (o,k).
    - err: e1[o][k] for o<2, e2[k] for o=2.
    - mbit: msg[k]·MSG_SCALE for o=2, else 0.
  - Output registers therefore update progressively during MAC. They are held stable from DONE until the next LOAD.
- Output backpressure: DONE holds out_valid and the outputs constant indefinitely while out_ready=0.
- Back-to-back: after the DONE handshake, in_ready=1 on the next cycle; there is no accept in the same cycle as the output handshake.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; both are functions of state only.

Test Plan:
1. Reset check: assert rst_n=0 mid-clock -> immediately in_ready=1, out_valid=0, all ct = 0.
2. All A, t, r, e = 0, msg=4'b0101 -> ct_u = all 0, ct_v = {9,0,9,0} for coeff 0..3. out_valid rises exactly 97 edges after accept.
3. Negacyclic wrap:
   - Stimulus: A00=[0,1,0,0], r0=[0,0,0,1], t0=[1,0,0,0], all else 0, msg=0.
   - Response: u0 = [16,0,0,0] (x·x^3 = -1), u1 = 0, v = [0,0,0,1].
4. Normalisation: e1[0][0]=-1, e2[0]=-18, e2[1]=35, all else 0, msg=0 -> u0[0]=16, v[0]=16, v[1]=1, all other coeffs 0.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new data.
   - Response: out_valid stays 1, outputs stay stable, in_ready=0, no second accept.
   - Then raise out_ready for 1 cycle -> IDLE, second bundle accepted next cycle, correct second result.
6. Reset mid-MAC: drop rst_n at cycle 40 of MAC -> outputs 0, out_valid never asserted. Rerun test 3 after release -> correct result at 97-edge latency.
